// File: rtl/filt_pkg.sv
// Shared types and frame constants for the wave-filter output path
// (remap stage, pixel writer, display reader).
package filt_pkg;

  localparam int FRAME_W = 240;
  localparam int FRAME_H = 320;
  localparam int ADDR_W  = 17;

  typedef logic [6:0] pix_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    pix_t              pix;
  } wr_entry_t;

  typedef enum logic [1:0] {
    STREAM = 2'd0,
    DRAIN  = 2'd1,
    DONE   = 2'd2
  } writer_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head. The caller must only push
// when not full (or when popping in the same cycle) and only pop when not empty.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  import filt_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  // NOTE: storage is deliberately not reset; only the pointers define
  // which entries are live, and a reset array would not map onto RAM.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // The extra pointer bit tells a full ring from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head  = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/filt_pixel_writer.sv
// Scatters remapped pixels into the filtered-frame BRAM at v*WIDTH+h,
// buffering around write-port stalls and flagging when a frame is fully written.
module filt_pixel_writer #(
  parameter int WIDTH      = filt_pkg::FRAME_W,
  parameter int HEIGHT     = filt_pkg::FRAME_H,
  parameter int ADDR_W     = filt_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              data_valid_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic [6:0]        pixel_in,
  input  logic              frame_end_in,
  input  logic              bram_grant_in,
  output logic              ready_out,
  output logic              we_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [6:0]        data_out,
  output logic              frame_done_out,
  output logic [15:0]       drop_count_out,
  output logic [15:0]       ovf_count_out
);
  import filt_pkg::*;

  localparam int DATA_W = ADDR_W + $bits(pix_t);

  writer_state_t state, state_nxt;

  logic        s0_valid, s0_fe;
  logic [10:0] s0_h;
  logic [9:0]  s0_v;
  pix_t        s0_pix;
  logic        s0_in_range;
  logic [ADDR_W-1:0] s0_addr;

  logic        s1_valid, s1_drop, s1_fe;
  logic [ADDR_W-1:0] s1_addr;
  pix_t        s1_pix;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  // Compare on zero-extended values so an oversized hcount can never wrap into range.
  assign s0_in_range = (32'(s0_h) < 32'(WIDTH)) && (32'(s0_v) < 32'(HEIGHT));
  assign s0_addr     = ADDR_W'(32'(s0_v) * 32'(WIDTH) + 32'(s0_h));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s0_valid <= 1'b0;
      s0_fe    <= 1'b0;
      s0_h     <= '0;
      s0_v     <= '0;
      s0_pix   <= '0;
      s1_valid <= 1'b0;
      s1_drop  <= 1'b0;
      s1_fe    <= 1'b0;
      s1_addr  <= '0;
      s1_pix   <= '0;
    end else begin
      // Input is only taken while streaming; DRAIN/DONE ignore it.
      s0_valid <= data_valid_in && (state == STREAM);
      s0_fe    <= frame_end_in && (state == STREAM);
      s0_h     <= hcount_in;
      s0_v     <= vcount_in;
      s0_pix   <= pixel_in;
      s1_valid <= s0_valid && s0_in_range;
      s1_drop  <= s0_valid && !s0_in_range;
      s1_fe    <= s0_fe;
      s1_addr  <= s0_addr;
      s1_pix   <= s0_pix;
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign fifo_pop  = bram_grant_in && !fifo_empty;
  assign fifo_push = s1_valid && (!fifo_full || fifo_pop);

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wdata  ({s1_addr, s1_pix}),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

  assign we_out   = fifo_pop;
  assign addr_out = fifo_empty ? '0 : fifo_head[DATA_W-1 -: ADDR_W];
  assign data_out = fifo_empty ? '0 : fifo_head[$bits(pix_t)-1:0];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      drop_count_out <= '0;
      ovf_count_out  <= '0;
    end else begin
      if (s1_drop && drop_count_out != 16'hFFFF)
        drop_count_out <= drop_count_out + 16'd1;
      if (s1_valid && fifo_full && !fifo_pop && ovf_count_out != 16'hFFFF)
        ovf_count_out <= ovf_count_out + 16'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= STREAM;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_nxt      = state;
    ready_out      = 1'b0;
    frame_done_out = 1'b0;
    unique case (state)
      STREAM: begin
        ready_out = 1'b1;
        if (s1_fe) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!s0_valid && !s1_valid && fifo_empty) state_nxt = DONE;
      end
      DONE: begin
        frame_done_out = 1'b1;
        state_nxt      = STREAM;
      end
      default: state_nxt = STREAM;
    endcase
  end

endmodule

// File: tb/tb_filt_pixel_writer.sv
// Scoreboard bench for filt_pixel_writer: expected BRAM writes are queued at
// drive time and compared in order as we_out fires.
module tb_filt_pixel_writer;
  import filt_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        data_valid_in = 1'b0;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic [6:0]  pixel_in = '0;
  logic        frame_end_in = 1'b0;
  logic        bram_grant_in = 1'b0;
  logic        ready_out, we_out, frame_done_out;
  logic [ADDR_W-1:0] addr_out;
  logic [6:0]  data_out;
  logic [15:0] drop_count_out, ovf_count_out;

  int n_cmp = 0;
  int n_err = 0;
  int done_count = 0;
  int wr_count = 0;
  wr_entry_t exp_q[$];
  wr_entry_t mon_e;

  always #5 clk_in = ~clk_in;

  filt_pixel_writer dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .data_valid_in  (data_valid_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .pixel_in       (pixel_in),
    .frame_end_in   (frame_end_in),
    .bram_grant_in  (bram_grant_in),
    .ready_out      (ready_out),
    .we_out         (we_out),
    .addr_out       (addr_out),
    .data_out       (data_out),
    .frame_done_out (frame_done_out),
    .drop_count_out (drop_count_out),
    .ovf_count_out  (ovf_count_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one input cycle; queue the expected write when the pixel should land.
  task automatic send(input int h, input int v, input int px, input logic fe, input logic keep);
    wr_entry_t e;
    @(posedge clk_in); #1;
    data_valid_in = 1'b1;
    hcount_in     = 11'(h);
    vcount_in     = 10'(v);
    pixel_in      = 7'(px);
    frame_end_in  = fe;
    if (keep) begin
      e.addr = ADDR_W'(v * FRAME_W + h);
      e.pix  = 7'(px);
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(posedge clk_in); #1;
    data_valid_in = 1'b0;
    frame_end_in  = 1'b0;
  endtask

  task automatic set_grant(input logic g);
    @(posedge clk_in); #1;
    bram_grant_in = g;
  endtask

  always @(negedge clk_in) begin
    if (frame_done_out) done_count++;
    if (we_out) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("spurious_we", 32'(we_out), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(addr_out), 32'(mon_e.addr));
        check("wr_data", 32'(data_out), 32'(mon_e.pix));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int  w0, d0;
    bit  seen;

    // Reset state
    repeat (3) @(negedge clk_in);
    check("rst_we",    32'(we_out), 32'd0);
    check("rst_ready", 32'(ready_out), 32'd1);
    check("rst_addr",  32'(addr_out), 32'd0);
    check("rst_data",  32'(data_out), 32'd0);
    check("rst_done",  32'(frame_done_out), 32'd0);
    check("rst_drop",  32'(drop_count_out), 32'd0);
    check("rst_ovf",   32'(ovf_count_out), 32'd0);
    rst_in = 1'b0;

    // Corner pixels with the port always granted
    set_grant(1'b1);
    send(0, 0, 5, 1'b0, 1'b1);
    send(239, 319, 7, 1'b0, 1'b1);
    idle();
    repeat (6) @(negedge clk_in);
    check("t1_drained", 32'(exp_q.size()), 32'd0);
    check("t1_writes",  32'(wr_count), 32'd2);
    check("t1_drop",    32'(drop_count_out), 32'd0);

    // Out-of-range coordinates are dropped
    w0 = wr_count;
    send(240, 10, 1, 1'b0, 1'b0);
    send(5, 320, 2, 1'b0, 1'b0);
    idle();
    repeat (5) @(negedge clk_in);
    check("t2_drop",   32'(drop_count_out), 32'd2);
    check("t2_no_wr",  32'(wr_count - w0), 32'd0);

    // Stalled port: first 8 buffered, remaining 4 overflow
    set_grant(1'b0);
    for (int i = 0; i < 12; i++) send(i, 1, i, 1'b0, i < 8);
    idle();
    repeat (4) @(negedge clk_in);
    check("t3_ovf",     32'(ovf_count_out), 32'd4);
    check("t3_we_low",  32'(we_out), 32'd0);
    check("t3_queued",  32'(exp_q.size()), 32'd8);
    w0 = wr_count;
    set_grant(1'b1);
    repeat (12) @(negedge clk_in);
    check("t3_writes",  32'(wr_count - w0), 32'd8);
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // FIFO held at 7/8 with push+pop landing on a full FIFO
    set_grant(1'b0);
    for (int i = 0; i < 7; i++) send(i, 2, i + 20, 1'b0, 1'b1);
    idle();
    repeat (3) @(posedge clk_in);
    begin
      int n;
      wr_entry_t e;
      n = 0;
      for (int k = 0; k < 18; k++) begin
        @(posedge clk_in); #1;
        frame_end_in  = 1'b0;
        bram_grant_in = (k >= 2) && (k % 3 != 2);
        if (k % 3 != 2) begin
          data_valid_in = 1'b1;
          hcount_in     = 11'(n);
          vcount_in     = 10'd3;
          pixel_in      = 7'(n + 40);
          e.addr = ADDR_W'(3 * FRAME_W + n);
          e.pix  = 7'(n + 40);
          exp_q.push_back(e);
          n++;
        end else begin
          data_valid_in = 1'b0;
        end
      end
      @(posedge clk_in); #1;
      data_valid_in = 1'b0;
      bram_grant_in = 1'b1;
    end
    repeat (14) @(negedge clk_in);
    check("t4_ovf",     32'(ovf_count_out), 32'd4);
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // Frame end coincident with the last pixel, grant delayed
    set_grant(1'b0);
    d0 = done_count;
    send(100, 319, 3, 1'b1, 1'b1);
    idle();
    repeat (5) @(negedge clk_in);
    check("t5_ready_low", 32'(ready_out), 32'd0);
    check("t5_no_done",   32'(done_count - d0), 32'd0);
    set_grant(1'b1);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk_in);
      if (frame_done_out) seen = 1'b1;
    end
    check("t5_done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("t5_write_first", 32'(exp_q.size()), 32'd0);
      @(negedge clk_in);
      check("t5_done_pulse", 32'(frame_done_out), 32'd0);
      check("t5_ready_back", 32'(ready_out), 32'd1);
    end
    repeat (3) @(negedge clk_in);
    check("t5_done_count", 32'(done_count - d0), 32'd1);

    // Asynchronous reset while draining with 4 entries queued
    set_grant(1'b0);
    for (int i = 0; i < 4; i++) send(i, 4, i + 60, i == 3, 1'b1);
    idle();
    repeat (5) @(negedge clk_in);
    check("t6_in_drain", 32'(ready_out), 32'd0);
    d0 = done_count;
    @(posedge clk_in); #2;
    bram_grant_in = 1'b1;
    #1;
    check("t6_we_before", 32'(we_out), 32'd1);
    rst_in = 1'b1;
    #1;
    check("t6_we_async", 32'(we_out), 32'd0);
    exp_q.delete();
    check("t6_ready", 32'(ready_out), 32'd1);
    check("t6_drop",  32'(drop_count_out), 32'd0);
    check("t6_ovf",   32'(ovf_count_out), 32'd0);
    check("t6_done",  32'(frame_done_out), 32'd0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (6) @(negedge clk_in);
    check("t6_no_done", 32'(done_count - d0), 32'd0);
    check("t6_idle_we", 32'(we_out), 32'd0);
    check("t6_ready2",  32'(ready_out), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
